// File: rtl/range_pkg.sv
// Shared types and widths for the range_scan host reader.
// No logic; constants only.
// No flow control; constants only.
package range_pkg;

    localparam int COUNT_BITS = 16;
    localparam int N_BITS     = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_READ   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FIN    = 3'd5
    } range_scan_state_t;

endpackage

// File: rtl/range_scan_if.sv
// Initiator-side link between range_scan and the range engine.
// Combinational wires only; no latency of its own.
// No backpressure: range answers fills with a done pulse and reads with fixed 1-cycle latency.
interface range_scan_if;
    import range_pkg::*;

    logic                  r_go;
    logic [N_BITS-1:0]     r_start;
    logic                  r_done;
    logic [COUNT_BITS-1:0] r_count;

    modport master (output r_go, output r_start, input r_done, input r_count);
    modport slave  (input r_go, input r_start, output r_done, output r_count);

endinterface

// File: rtl/range_max_tracker.sv
// Running maximum (lowest index wins ties) over a stream of indexed counts; optional total.
// Result visible the cycle after the last valid sample.
// No backpressure: accepts one sample per cycle whenever i_vld is high.
// Optional total output enabled by RANGE_SCAN_SUM_EN.
module range_max_tracker
    import range_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_vld,
    input  logic [RAM_ADDR_BITS-1:0] i_idx,
    input  logic [COUNT_BITS-1:0]    i_count,
`ifdef RANGE_SCAN_SUM_EN
    output logic [COUNT_BITS+RAM_ADDR_BITS-1:0] o_sum,
`endif
    output logic [COUNT_BITS-1:0]    o_max_count,
    output logic [RAM_ADDR_BITS-1:0] o_max_idx
);

    logic [COUNT_BITS-1:0]    r_max;
    logic [RAM_ADDR_BITS-1:0] r_idx;

    // Strict compare: samples arrive in increasing index order, so an equal later value never displaces the first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (i_clear) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (i_vld && (i_count > r_max)) begin
            r_max <= i_count;
            r_idx <= i_idx;
        end
    end

    assign o_max_count = r_max;
    assign o_max_idx   = r_idx;

`ifdef RANGE_SCAN_SUM_EN
    logic [COUNT_BITS+RAM_ADDR_BITS-1:0] r_sum;

    // Width leaves RAM_ADDR_BITS of headroom, enough for 2**RAM_ADDR_BITS full-scale counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_vld) begin
            r_sum <= r_sum + (COUNT_BITS+RAM_ADDR_BITS)'(i_count);
        end
    end

    assign o_sum = r_sum;
`endif

endmodule

// File: rtl/range_scan.sv
// Launches one range fill from base, reads back all counts, reports max count/index/start number.
// go to done: 1 + 1 + fill time + RAM_WORDS + 1 + 1 cycles.
// No backpressure: go is only honoured in IDLE; range is expected to keep pace (done pulse, 1-cycle reads).
// Optional RANGE_SCAN_SUM_EN adds the sum output (total of all counts).
module range_scan
    import range_pkg::*;
#(
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     go,
    input  logic [N_BITS-1:0]        base,
    output logic                     busy,
    output logic                     done,
    output logic [COUNT_BITS-1:0]    max_count,
    output logic [RAM_ADDR_BITS-1:0] max_idx,
    output logic [N_BITS-1:0]        max_n,
`ifdef RANGE_SCAN_SUM_EN
    output logic [COUNT_BITS+RAM_ADDR_BITS-1:0] sum,
`endif
    range_scan_if.master             rif
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LAUNCH = ST_LAUNCH;
    localparam logic [2:0] S_WAIT   = ST_WAIT;
    localparam logic [2:0] S_READ   = ST_READ;
    localparam logic [2:0] S_DRAIN  = ST_DRAIN;
    localparam logic [2:0] S_FIN    = ST_FIN;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

    logic [2:0]               r_state;
    logic [N_BITS-1:0]        r_base;
    logic [RAM_ADDR_BITS-1:0] r_idx;
    logic                     r_pend;
    logic [RAM_ADDR_BITS-1:0] r_pend_idx;
    logic                     r_rgo;
    logic [N_BITS-1:0]        r_rstart;
    logic                     r_busy;
    logic                     r_done;
    logic [COUNT_BITS-1:0]    r_max_count;
    logic [RAM_ADDR_BITS-1:0] r_max_idx;
    logic [N_BITS-1:0]        r_max_n;

    logic [COUNT_BITS-1:0]    w_trk_max;
    logic [RAM_ADDR_BITS-1:0] w_trk_idx;
    logic                     w_clear;

`ifdef RANGE_SCAN_SUM_EN
    logic [COUNT_BITS+RAM_ADDR_BITS-1:0] w_trk_sum;
    logic [COUNT_BITS+RAM_ADDR_BITS-1:0] r_sum;
`endif

    // Accumulators restart while the engine is being launched; published results are untouched.
    assign w_clear = (r_state == S_LAUNCH);

    range_max_tracker #(
        .RAM_ADDR_BITS (RAM_ADDR_BITS)
    ) u_trk (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_clear),
        .i_vld       (r_pend),
        .i_idx       (r_pend_idx),
        .i_count     (rif.r_count),
`ifdef RANGE_SCAN_SUM_EN
        .o_sum       (w_trk_sum),
`endif
        .o_max_count (w_trk_max),
        .o_max_idx   (w_trk_idx)
    );

    // Scan FSM: r_pend marks that the word addressed last cycle is on r_count now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_idx       <= '0;
            r_pend      <= 1'b0;
            r_pend_idx  <= '0;
            r_rgo       <= 1'b0;
            r_rstart    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_max_count <= '0;
            r_max_idx   <= '0;
            r_max_n     <= '0;
`ifdef RANGE_SCAN_SUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_rgo  <= 1'b0;
            r_done <= 1'b0;
            r_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_base   <= base;
                        r_busy   <= 1'b1;
                        r_rgo    <= 1'b1;
                        r_rstart <= base;
                        r_state  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rif.r_done) begin
                        r_idx    <= '0;
                        r_rstart <= '0;
                        r_state  <= S_READ;
                    end
                end
                S_READ: begin
                    r_pend     <= 1'b1;
                    r_pend_idx <= r_idx;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_idx    <= r_idx + RAM_ADDR_BITS'(1);
                        r_rstart <= N_BITS'(r_idx) + N_BITS'(1);
                    end
                end
                S_DRAIN: begin
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    r_max_count <= w_trk_max;
                    r_max_idx   <= w_trk_idx;
                    r_max_n     <= r_base + N_BITS'(w_trk_idx);
`ifdef RANGE_SCAN_SUM_EN
                    r_sum       <= w_trk_sum;
`endif
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign max_count   = r_max_count;
    assign max_idx     = r_max_idx;
    assign max_n       = r_max_n;
    assign rif.r_go    = r_rgo;
    assign rif.r_start = r_rstart;
`ifdef RANGE_SCAN_SUM_EN
    assign sum         = r_sum;
`endif

endmodule

// File: tb/tb_range_scan.sv
// Bench for range_scan with a behavioural range engine and a scoreboard.
// Engine: done 20 cycles after go, 1-cycle read latency.
// Expected results are queued at each accepted go and consumed on each done.
module tb_range_scan;
    import range_pkg::*;

    localparam int RW = 16;
    localparam int AB = 4;

    typedef struct {
        logic [31:0] b;
        logic [15:0] mc;
        logic [3:0]  mi;
        logic [31:0] mn;
        logic [31:0] sm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [31:0] base = '0;
    logic        busy, done;
    logic [15:0] max_count;
    logic [3:0]  max_idx;
    logic [31:0] max_n;
`ifdef RANGE_SCAN_SUM_EN
    logic [19:0] sum;
`endif

    range_scan_if rif ();

    range_scan #(.RAM_WORDS(RW), .RAM_ADDR_BITS(AB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .base      (base),
        .busy      (busy),
        .done      (done),
        .max_count (max_count),
        .max_idx   (max_idx),
        .max_n     (max_n),
`ifdef RANGE_SCAN_SUM_EN
        .sum       (sum),
`endif
        .rif       (rif)
    );

    always #5 clk = ~clk;

    // Behavioural range engine (never reset).
    logic [15:0] ram [RW];
    int          fill_cnt = 0;

    always @(posedge clk) begin
        if (rif.r_go)          fill_cnt <= 20;
        else if (fill_cnt > 0) fill_cnt <= fill_cnt - 1;
        rif.r_done  <= (fill_cnt == 1) && !rif.r_go;
        rif.r_count <= ram[rif.r_start[3:0]];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
        end
    endtask

    // Reference: maximum value, then the first index holding it.
    function automatic exp_t model(input logic [31:0] b);
        exp_t e;
        int   mx = 0;
        int   total = 0;
        int   where = -1;
        foreach (ram[i]) begin
            if (int'(ram[i]) > mx) mx = int'(ram[i]);
            total += int'(ram[i]);
        end
        foreach (ram[i]) if (where < 0 && int'(ram[i]) == mx) where = i;
        e.b  = b;
        e.mc = 16'(mx);
        e.mi = 4'(where);
        e.mn = b + 32'(where);
        e.sm = 32'(total);
        return e;
    endfunction

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          rgo_cnt = 0;
    logic [31:0] rgo_start = '0;
    int          rd_cnt = 0;

    // Monitor: observes the range link and checks every done against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                addr_q.delete();
                rgo_cnt = 0;
                rd_cnt  = 0;
            end else begin
                if (rd_cnt > 0) begin
                    addr_q.push_back(rif.r_start);
                    rd_cnt--;
                end
                if (rif.r_done) rd_cnt = RW;
                if (rif.r_go) begin
                    rgo_cnt++;
                    rgo_start = rif.r_start;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: done seen with no scan outstanding");
                    end else begin
                        e = exp_q.pop_front();
                        chk("max_count", 32'(max_count), 32'(e.mc));
                        chk("max_idx", 32'(max_idx), 32'(e.mi));
                        chk("max_n", max_n, e.mn);
`ifdef RANGE_SCAN_SUM_EN
                        chk("sum", 32'(sum), e.sm);
`endif
                        chk("busy_at_done", 32'(busy), 32'd0);
                        chk("r_go_pulses", 32'(rgo_cnt), 32'd1);
                        chk("r_start_at_go", rgo_start, e.b);
                        chk("read_count", 32'(addr_q.size()), 32'(RW));
                        for (int i = 0; i < RW && i < addr_q.size(); i++)
                            chk("read_addr", addr_q[i], 32'(i));
                    end
                    rgo_cnt = 0;
                    addr_q.delete();
                end
            end
        end
    end

    task automatic start(input logic [31:0] b, output exp_t e);
        e = model(b);
        exp_q.push_back(e);
        go   = 1'b1;
        base = b;
        @(negedge clk);
        go   = 1'b0;
        base = $urandom;
        chk("busy_after_go", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: no done within 300 cycles");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic fill_rand(input int hi);
        foreach (ram[i]) ram[i] = 16'($urandom_range(0, hi));
    endtask

    task automatic chk_hold(input exp_t p);
        chk("hold_max_count", 32'(max_count), 32'(p.mc));
        chk("hold_max_idx", 32'(max_idx), 32'(p.mi));
        chk("hold_max_n", max_n, p.mn);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_max_count"}, 32'(max_count), 32'd0);
        chk({tag, "_max_idx"}, 32'(max_idx), 32'd0);
        chk({tag, "_max_n"}, max_n, 32'd0);
        chk({tag, "_r_go"}, 32'(rif.r_go), 32'd0);
        chk({tag, "_r_start"}, rif.r_start, 32'd0);
`ifdef RANGE_SCAN_SUM_EN
        chk({tag, "_sum"}, 32'(sum), 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] plan [RW];
        exp_t        e, p;
        plan = '{16'd0, 16'd1, 16'd7, 16'd2, 16'd5, 16'd8, 16'd16, 16'd3,
                 16'd19, 16'd6, 16'd14, 16'd9, 16'd9, 16'd17, 16'd17, 16'd4};
        foreach (ram[i]) ram[i] = plan[i];

        idle(3);
        chk_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Reference data set.
        start(32'd1, e);
        wait_done();
        chk("plan_max_count", 32'(max_count), 32'd19);
        chk("plan_max_idx", 32'(max_idx), 32'd8);
        chk("plan_max_n", max_n, 32'd9);
`ifdef RANGE_SCAN_SUM_EN
        chk("plan_sum", 32'(sum), 32'd137);
`endif
        idle(4);
        chk_hold(e);

        // Tie at entries 5 and 11.
        fill_rand(39);
        ram[5]  = 16'd40;
        ram[11] = 16'd40;
        start($urandom, e);
        wait_done();
        chk("tie_idx", 32'(max_idx), 32'd5);
        idle(2);

        // All-zero RAM, then a wrap of base + idx.
        foreach (ram[i]) ram[i] = 16'd0;
        start(32'hFFFF_FFF8, e);
        wait_done();
        idle(3);
        chk_hold(e);
        fill_rand(50);
        ram[10] = 16'd60;
        start(32'hFFFF_FFF8, e);
        wait_done();
        chk("wrap_max_n", max_n, 32'h0000_0002);
        idle(2);

        // Stray go during WAIT and during READ.
        fill_rand(1000);
        start(32'd100, e);
        idle(5);
        go = 1'b1; base = 32'd555;
        @(negedge clk);
        go = 1'b0;
        idle(22);
        go = 1'b1; base = 32'd777;
        @(negedge clk);
        go = 1'b0;
        wait_done();
        idle(60);
        p = e;

        // Reset while reading.
        fill_rand(500);
        start($urandom, e);
        idle(8);
        chk_hold(p);
        idle(20);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        idle(2);
        rst_n = 1'b1;
        idle(2);
        fill_rand(65535);
        start($urandom, e);
        wait_done();

        // Back-to-back scans with random data.
        for (int r = 0; r < 6; r++) begin
            p = e;
            @(negedge clk);
            fill_rand((r % 2 == 0) ? 65535 : 3);
            start($urandom, e);
            idle(3);
            chk_hold(p);
            wait_done();
        end

        idle(5);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
